my_uart_tx: RTL and testbench



---
 rtl/my_uart_tx.sv | 148 ++++++++++++++
 tb/tb_my_uart_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/my_uart_tx.sv
// my_uart_tx: UART transmitter, 8N1; define UART_TX_PARITY_EN for 8E1 (even parity bit before stop).
// Latency: tx falls 1 cycle after an accepted start; done pulses 10 (11 with parity) bit-times later.
// Backpressure: busy is high while a frame is in flight and start is ignored until busy drops.
module my_uart_tx #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W = ($clog2(CLKS_PER_BIT) > 14) ? $clog2(CLKS_PER_BIT) : 14;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic tick;
    logic accept;

    assign tick   = (cnt_q == LAST);
    assign accept = (state_q == IDLE) && start && !busy_q;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    // Every state transition happens on a tick, so the counter wrap doubles as the clear on entry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = START;
                    shreg_d = data_in;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^data_in;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is registered from the next state so the line changes exactly on state boundaries.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = busy_q;
        done_d = 1'b0;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
        if (accept) busy_d = 1'b1;
        if ((state_q == STOP) && tick) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_my_uart_tx.sv
// Bench for my_uart_tx with a short bit period; frames are checked cycle by cycle against a frame model.
module tb_my_uart_tx;
    localparam int N = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_l;
    logic       start;
    logic [7:0] data_in;
    logic       tx, busy, done;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;   // bit k is the k-th bit on the line
    } vec_t;
    vec_t tbl[6];

    my_uart_tx #(.CLK_HZ(N), .BAUD(1)) dut (
        .clk     (clk),
        .rst_l   (rst_l),
        .start   (start),
        .data_in (data_in),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame built from the line rules: start 0, data LSB first, optional even parity, stop 1.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        bit q[$];
        logic [10:0] f;
        int ones;
        f = '0;
        ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            q.push_back(d[i]);
            ones += int'(d[i]);
        end
`ifdef UART_TX_PARITY_EN
        q.push_back((ones % 2) == 1);
`endif
        q.push_back(1'b1);
        for (int i = 0; i < q.size(); i++) f[i] = q[i];
        return f;
    endfunction

    // Starts a frame; returns at the negedge of the first tx-low cycle.
    task automatic launch(input logic [7:0] d, input bit hold, input logic [7:0] nxt);
        int w;
        w = 0;
        while (busy !== 1'b0 && w < 4 * NB * N) begin
            @(negedge clk);
            w++;
        end
        chk("launch_idle", busy, 0);
        start   = 1'b1;
        data_in = d;
        @(negedge clk);
        data_in = nxt;
        if (!hold) start = 1'b0;
        chk("start_low", tx, 0);
        chk("busy_set", busy, 1);
    endtask

    // Follows the frame from its first low cycle to the done cycle.
    task automatic capture(input logic [10:0] exp, input string name, input int inject_at);
        logic [10:0] got;
        int off;
        int bad;
        got = '0;
        off = 0;
        bad = 0;
        while (done !== 1'b1 && off < NB * N + 4 * N) begin
            if (off < NB * N) begin
                if (tx !== exp[off / N]) bad++;
                if (off % N == N / 2) got[off / N] = tx;
            end
            if (busy !== 1'b1) bad++;
            if (off == inject_at) begin
                start   = 1'b1;
                data_in = 8'hFF;
            end
            if (off == inject_at + 3) start = 1'b0;
            @(negedge clk);
            off++;
        end
        chk({name, "_bits"}, got, exp);
        chk({name, "_wave"}, bad, 0);
        chk({name, "_done_at"}, off, NB * N);
        chk({name, "_busy_at_done"}, busy, 0);
    endtask

    task automatic finish_frame(input string name);
        @(negedge clk);
        chk({name, "_done_width"}, done, 0);
        chk({name, "_idle_tx"}, tx, 1);
    endtask

    initial begin
`ifdef UART_TX_PARITY_EN
        tbl[0] = '{8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}};
        tbl[1] = '{8'h3C, {1'b1, 1'b0, 8'h3C, 1'b0}};
        tbl[2] = '{8'h55, {1'b1, 1'b0, 8'h55, 1'b0}};
        tbl[3] = '{8'h07, {1'b1, 1'b1, 8'h07, 1'b0}};
        tbl[4] = '{8'h81, {1'b1, 1'b0, 8'h81, 1'b0}};
        tbl[5] = '{8'h6E, {1'b1, 1'b1, 8'h6E, 1'b0}};
`else
        tbl[0] = '{8'hA5, {1'b0, 1'b1, 8'hA5, 1'b0}};
        tbl[1] = '{8'h3C, {1'b0, 1'b1, 8'h3C, 1'b0}};
        tbl[2] = '{8'h55, {1'b0, 1'b1, 8'h55, 1'b0}};
        tbl[3] = '{8'h07, {1'b0, 1'b1, 8'h07, 1'b0}};
        tbl[4] = '{8'h81, {1'b0, 1'b1, 8'h81, 1'b0}};
        tbl[5] = '{8'h6E, {1'b0, 1'b1, 8'h6E, 1'b0}};
`endif

        // Reset held with start asserted: line must stay idle.
        rst_l   = 1'b0;
        start   = 1'b1;
        data_in = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rst_tx_%0d", i), tx, 1);
            chk($sformatf("rst_busy_%0d", i), busy, 0);
            chk($sformatf("rst_done_%0d", i), done, 0);
        end
        start = 1'b0;
        rst_l = 1'b1;
        @(negedge clk);
        chk("post_rst_tx", tx, 1);
        chk("post_rst_busy", busy, 0);

        // Table vectors; vector 1 also gets a start for 0xFF injected during DATA.
        for (int i = 0; i < 6; i++) begin
            launch(tbl[i].data, 1'b0, 8'($urandom));
            capture(tbl[i].frame, $sformatf("vec%0d", i), (i == 1) ? 3 * N : -100);
            finish_frame($sformatf("vec%0d", i));
            if (i == 1) begin
                int bad;
                bad = 0;
                for (int k = 0; k < 3 * N; k++) begin
                    if (tx !== 1'b1 || busy !== 1'b0) bad++;
                    @(negedge clk);
                end
                chk("reject_no_frame", bad, 0);
            end
        end

        // Back-to-back with start held high: only the done cycle separates the frames.
        launch(8'h00, 1'b1, 8'hFF);
        capture(ref_frame(8'h00), "b2b_a", -100);
        @(negedge clk);
        chk("b2b_done_width", done, 0);
        chk("b2b_gap", tx, 0);
        chk("b2b_busy", busy, 1);
        start   = 1'b0;
        data_in = 8'($urandom);
        capture(ref_frame(8'hFF), "b2b_b", -100);
        finish_frame("b2b_b");

        // Reset during data bit 3 of 0x55.
        launch(8'h55, 1'b0, 8'($urandom));
        repeat (4 * N + N / 2) @(negedge clk);
        chk("midrst_pre_tx", tx, 0);
        rst_l = 1'b0;
        @(negedge clk);
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        launch(8'h55, 1'b0, 8'($urandom));
        capture(ref_frame(8'h55), "after_rst", -100);
        finish_frame("after_rst");

        // Random bytes with random idle gaps.
        for (int i = 0; i < 10; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            launch(d, 1'b0, 8'($urandom));
            capture(ref_frame(d), $sformatf("rnd%0d", i), -100);
            finish_frame($sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
